cordic_share_arbiter: RTL and testbench
=======================================

// Module: cordic_share_arbiter
// PURPOSE
//   Shares one pipelined CORDIC (8-bit signed Q2.6 angle in, Q1.7 sine/cosine out, no valid/stall) among
//   N_REQ requesters. Round-robin arbitration issues at most one angle per cycle, with a per-requester
//   outstanding-request limit. A tag delay line matched to the CORDIC latency routes each result back with
//   its requester ID. Sits between client blocks and the cordic instance; this block drives the instance input.
// PARAMETERS
//   N_REQ    4   number of requesters (2..8)
//   LAT      8   CORDIC latency in cycles, input sample to matching sine/cosine; must match the instance
//   MAX_OUT  2   max in-flight requests per requester (1..LAT+2)
//   ID_W     2   requester ID width, = clog2(N_REQ)
// PORTS
//   clk         in   1          clock, rising edge
//   rst         in   1          asynchronous, active-low reset
//   req_valid   in   N_REQ      request i present
//   req_angle   in   8*N_REQ    angle for requester i in bits [8i+7:8i], signed Q2.6
//   req_ready   out  N_REQ      one-hot grant; transfer = req_valid[i] & req_ready[i]
//   cor_angle   out  8          registered angle to CORDIC input
//   cor_sine    in   8          CORDIC sine output, Q1.7
//   cor_cosine  in   8          CORDIC cosine output, Q1.7
//   rsp_valid   out  1          result valid, single-cycle pulse, no backpressure
//   rsp_id      out  ID_W       requester that owns the result
//   rsp_sine    out  8          registered sine
//   rsp_cosine  out  8          registered cosine
//   busy        out  1          any request in flight (issue reg, tag line or rsp reg)
// BEHAVIOUR
//   - Reset (rst=0) clears asynchronously:
//     - every output register to 0;
//     - the tag delay line and all outstanding counters;
//     - the RR pointer, so requester 0 has top priority.
//     While rst=0, req_ready=0.
//   - Eligibility: eligible[i] = req_valid[i] & (out_cnt[i] < MAX_OUT).
//   - Grant selection (combinational):
//     - Choose the first eligible index searching from last_grant+1 upward, with wrap-around.
//     - req_ready is one-hot or zero.
//     - last_grant updates only on a transfer.
//   - Requesters may drop req_valid without a transfer. req_angle must be stable while valid and not ready.
//   - Issue: on a transfer, cor_angle <= granted angle and tag[0] <= {1, id}. With no transfer, cor_angle <= 0
//     and tag[0] valid <= 0. The angle is passed through unmodified, with no range check.
//   - Tag line: a LAT-deep shift register of {valid, id}, advancing every cycle and aligned with the CORDIC pipe.
//   - Response: rsp_valid <= tag[LAT-1].valid and rsp_id <= tag[LAT-1].id. rsp_sine/rsp_cosine load cor_sine/cor_cosine
//     only when tag[LAT-1].valid, and otherwise hold their value.
//   - Latency: a transfer in cycle t produces cor_angle in cycle t+1 and rsp_valid in cycle t+LAT+2, fixed.
//     Throughput is one result per cycle.
//   - Outstanding counters, width clog2(MAX_OUT+1):
//     - out_cnt[i] increments on a transfer for i and decrements when rsp_valid & rsp_id==i.
//     - A simultaneous increment and decrement leaves the counter unchanged.
//     - A counter never exceeds MAX_OUT and never underflows.
//     - A decrement takes effect at the clock edge ending the rsp_valid cycle, so eligibility returns the next cycle.
//   - busy = |out_cnt.
//   - Reset mid-operation: in-flight results are discarded. After rst releases, the stale CORDIC outputs
//     still draining from the instance are never flagged, because the tag line is cleared.
// TESTING
//   T1 Single request: req 0 sends 8'h0E (0.21875 rad) -> req_ready[0]=1 the same cycle; rsp_valid exactly LAT+2 cycles later
//      with rsp_id=0, rsp_sine ~8'h1C and rsp_cosine ~8'h7D (within +/-2 LSB of a $sin/$cos model); busy then returns to 0.
//   T2 All 4 requesters continuously valid with distinct angles -> grants 0,1,2,3,0,... one per cycle;
//      rsp_id follows the same order; every result matches its angle.
//   T3 MAX_OUT=2, LAT=8, only requester 2 valid -> accepts in cycles 0,1; req_ready[2]=0 in cycles 2..10;
//      rsp_valid in cycles 10,11; next accept in cycle 11.
//   T4 Last grant = 3, requesters 1 and 3 valid -> grant 1, then 3, then 1 (wrap-around fairness).
//   T5 rst pulsed low with 3 requests in flight -> all outputs 0 immediately; no rsp_valid for the next LAT+2 cycles
//      after release; first new grant goes to requester 0.
//   T6 Requester 1 is accepted in the same cycle its earlier result has rsp_valid -> out_cnt[1] unchanged;
//      busy stays 1; no underflow or overflow.

Source files
------------

// File: rtl/cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_share_arbiter
//
// Shares one pipelined CORDIC (Q2.6 angle in, Q1.7 sine/cosine out, fixed
// latency, no handshake) among N_REQ requesters. A round-robin arbiter issues
// at most one angle per cycle. Each requester has a cap on its in-flight
// requests. A {valid, id} tag travels alongside the CORDIC pipe so that every
// result is returned with the ID of the requester that issued it.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   req_valid   per-requester request strobe
//   req_angle   per-requester Q2.6 angle, requester i in bits [8i+7:8i]
//   req_ready   one-hot (or zero) grant; transfer = req_valid[i] & req_ready[i]
//   cor_angle   registered angle driven into the CORDIC instance
//   cor_sine    CORDIC sine output (Q1.7)
//   cor_cosine  CORDIC cosine output (Q1.7)
//   rsp_valid   single-cycle result strobe, no backpressure
//   rsp_id      requester that owns the current result
//   rsp_sine    registered sine, held between results
//   rsp_cosine  registered cosine, held between results
//   busy        at least one request is in flight anywhere in the path
// -----------------------------------------------------------------------------
module cordic_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LAT     = 8,
    parameter int MAX_OUT = 2,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_angle,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           cor_angle,
    input  logic [7:0]           cor_sine,
    input  logic [7:0]           cor_cosine,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_sine,
    output logic [7:0]           rsp_cosine,
    output logic                 busy
);

    localparam int              CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    // Pointer value meaning "requester N_REQ-1 was served last", which makes
    // requester 0 the first candidate of the search.
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

    // Round-robin pointer and per-requester in-flight counters
    logic [ID_W-1:0]             last_grant_q, last_grant_d;
    logic [N_REQ-1:0][CNT_W-1:0] out_cnt_q, out_cnt_d;

    // Issue stage: the angle register plus its tag, which together form the
    // first stage of the path toward the CORDIC. The tag line proper starts
    // one stage later so it lines up with the instance's internal pipeline.
    logic                        issue_vld_q, issue_vld_d;
    logic [ID_W-1:0]             issue_id_q, issue_id_d;
    logic [7:0]                  cor_angle_q, cor_angle_d;

    // Tag delay line, index 0 is the youngest entry
    logic [LAT-1:0]              tag_vld_q, tag_vld_d;
    logic [LAT-1:0][ID_W-1:0]    tag_id_q, tag_id_d;

    // Response registers
    logic                        rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]             rsp_id_q, rsp_id_d;
    logic [7:0]                  rsp_sine_q, rsp_sine_d;
    logic [7:0]                  rsp_cosine_q, rsp_cosine_d;

    // Arbitration intermediates
    logic [N_REQ-1:0]            eligible_s;
    logic [N_REQ-1:0]            grant_s;
    logic                        grant_vld_s;
    logic [ID_W-1:0]             grant_id_s;
    logic [7:0]                  grant_angle_s;
    logic                        xfer_s;
    logic                        hi_found_s, lo_found_s;
    logic [ID_W-1:0]             hi_id_s, lo_id_s;
    logic [N_REQ-1:0]            inc_s, dec_s;

    // Eligibility: valid and below the in-flight cap
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible_s[i] = req_valid[i] & (out_cnt_q[i] < MAX_CNT);
        end
    end

    // Round-robin pick: lowest eligible index above the pointer, otherwise
    // lowest eligible index overall (the wrap-around case).
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_id_s    = '0;
        lo_id_s    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi_id_s    = (eligible_s[i] & ~hi_found_s & (ID_W'(i) > last_grant_q)) ? ID_W'(i) : hi_id_s;
            hi_found_s = hi_found_s | (eligible_s[i] & (ID_W'(i) > last_grant_q));
            lo_id_s    = (eligible_s[i] & ~lo_found_s) ? ID_W'(i) : lo_id_s;
            lo_found_s = lo_found_s | eligible_s[i];
        end
        grant_vld_s = hi_found_s | lo_found_s;
        grant_id_s  = hi_found_s ? hi_id_s : lo_id_s;
    end

    // One-hot grant vector and the angle of the granted requester
    always_comb begin
        grant_s       = '0;
        grant_angle_s = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            grant_s[i]    = grant_vld_s & (grant_id_s == ID_W'(i));
            grant_angle_s = grant_s[i] ? req_angle[8*i +: 8] : grant_angle_s;
        end
    end

    // Grants are suppressed while reset is asserted, so nothing transfers
    assign xfer_s    = grant_vld_s & rst;
    assign req_ready = grant_s & {N_REQ{rst}};

    // Next state of the pointer, issue stage, tag line and response registers
    always_comb begin
        last_grant_d = xfer_s ? grant_id_s : last_grant_q;
        issue_vld_d  = xfer_s;
        issue_id_d   = xfer_s ? grant_id_s : {ID_W{1'b0}};
        cor_angle_d  = xfer_s ? grant_angle_s : 8'h00;
        tag_vld_d    = {tag_vld_q[LAT-2:0], issue_vld_q};
        tag_id_d     = {tag_id_q[LAT-2:0], issue_id_q};
        rsp_valid_d  = tag_vld_q[LAT-1];
        rsp_id_d     = tag_id_q[LAT-1];
        rsp_sine_d   = tag_vld_q[LAT-1] ? cor_sine   : rsp_sine_q;
        rsp_cosine_d = tag_vld_q[LAT-1] ? cor_cosine : rsp_cosine_q;
    end

    // In-flight counters: up on a transfer, down once the response cycle ends;
    // both at once cancel. Saturation guards keep the count within 0..MAX_OUT.
    always_comb begin
        inc_s     = '0;
        dec_s     = '0;
        out_cnt_d = out_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            inc_s[i] = xfer_s & (grant_id_s == ID_W'(i));
            dec_s[i] = rsp_valid_q & (rsp_id_q == ID_W'(i));
            case ({inc_s[i], dec_s[i]})
                2'b10:   out_cnt_d[i] = (out_cnt_q[i] < MAX_CNT) ? (out_cnt_q[i] + CNT_W'(1)) : out_cnt_q[i];
                2'b01:   out_cnt_d[i] = (out_cnt_q[i] != CNT_W'(0)) ? (out_cnt_q[i] - CNT_W'(1)) : out_cnt_q[i];
                default: out_cnt_d[i] = out_cnt_q[i];
            endcase
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PTR_RST;
            out_cnt_q    <= '0;
            issue_vld_q  <= 1'b0;
            issue_id_q   <= '0;
            cor_angle_q  <= 8'h00;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sine_q   <= 8'h00;
            rsp_cosine_q <= 8'h00;
        end else begin
            last_grant_q <= last_grant_d;
            out_cnt_q    <= out_cnt_d;
            issue_vld_q  <= issue_vld_d;
            issue_id_q   <= issue_id_d;
            cor_angle_q  <= cor_angle_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sine_q   <= rsp_sine_d;
            rsp_cosine_q <= rsp_cosine_d;
        end
    end

    assign cor_angle  = cor_angle_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_sine   = rsp_sine_q;
    assign rsp_cosine = rsp_cosine_q;
    // Counters cover the issue stage, tag line and response register
    assign busy       = |out_cnt_q;

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_share_arbiter
//
// Directed bench for cordic_share_arbiter. A behavioural CORDIC (real-valued
// sine/cosine behind an LAT-stage delay) stands in for the shared instance.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_cordic_share_arbiter;

    localparam int N_REQ   = 4;
    localparam int LAT     = 8;
    localparam int MAX_OUT = 2;
    localparam int ID_W    = 2;

    logic                   clk       = 1'b0;
    logic                   rst       = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [8*N_REQ-1:0]     req_angle = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [7:0]             cor_angle;
    logic [7:0]             cor_sine;
    logic [7:0]             cor_cosine;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [7:0]             rsp_sine;
    logic [7:0]             rsp_cosine;
    logic                   busy;

    int check_cnt = 0;
    int err_cnt   = 0;

    logic [LAT-1:0][7:0]    sin_pipe = '0;
    logic [LAT-1:0][7:0]    cos_pipe = '0;

    logic [3:0] t2_rdy [22] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8,
                                4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [7:0] t2_ang [4]  = '{8'h10, 8'hF0, 8'h40, 8'hC0};
    logic [3:0] exp_rsp;
    int         exp_id;

    always #5 clk = ~clk;

    cordic_share_arbiter #(
        .N_REQ   (N_REQ),
        .LAT     (LAT),
        .MAX_OUT (MAX_OUT),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .cor_angle  (cor_angle),
        .cor_sine   (cor_sine),
        .cor_cosine (cor_cosine),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_sine   (rsp_sine),
        .rsp_cosine (rsp_cosine),
        .busy       (busy)
    );

    function automatic logic [7:0] to_q17(input real x);
        int v;
        v = int'(x * 128.0);
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic real angle_rad(input logic [7:0] a);
        return real'($signed(a)) / 64.0;
    endfunction

    // Behavioural CORDIC: angle sampled each edge, result LAT cycles later
    always @(posedge clk) begin
        sin_pipe <= {sin_pipe[LAT-2:0], to_q17($sin(angle_rad(cor_angle)))};
        cos_pipe <= {cos_pipe[LAT-2:0], to_q17($cos(angle_rad(cor_angle)))};
    end
    assign cor_sine   = sin_pipe[LAT-1];
    assign cor_cosine = cos_pipe[LAT-1];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state: grant held off even with every request valid
        @(negedge clk);
        req_valid = 4'hF;
        req_angle = 32'h0E0E_0E0E;
        #1;
        check_value("rst_ready",      32'(req_ready),  32'h0);
        check_value("rst_cor_angle",  32'(cor_angle),  32'h0);
        check_value("rst_rsp_valid",  32'(rsp_valid),  32'h0);
        check_value("rst_rsp_id",     32'(rsp_id),     32'h0);
        check_value("rst_rsp_sine",   32'(rsp_sine),   32'h0);
        check_value("rst_rsp_cosine", 32'(rsp_cosine), 32'h0);
        check_value("rst_busy",       32'(busy),       32'h0);
        do_reset();

        // T1: single request, fixed LAT+2 latency, busy drops afterwards
        @(negedge clk);
        req_valid = 4'b0001;
        req_angle = 32'h0000_000E;
        #1;
        check_value("t1_ready", 32'(req_ready), 32'h1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (c == 1) begin
                check_value("t1_cor_angle", 32'(cor_angle), 32'h0E);
                check_value("t1_busy", 32'(busy), 32'h1);
            end
            check_value("t1_rsp_valid", 32'(rsp_valid), 32'(c == 10));
            if (c == 10) begin
                check_value("t1_rsp_id",     32'(rsp_id),     32'h0);
                check_value("t1_rsp_sine",   32'(rsp_sine),   32'h1C);
                check_value("t1_rsp_cosine", 32'(rsp_cosine), 32'h7D);
            end
            if (c == 11) check_value("t1_busy_end", 32'(busy), 32'h0);
        end

        // T2: all four valid, round-robin order, cap stalls, results routed
        do_reset();
        req_angle = {t2_ang[3], t2_ang[2], t2_ang[1], t2_ang[0]};
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            req_valid = (c < 12) ? 4'hF : 4'h0;
            #1;
            check_value("t2_ready", 32'(req_ready), 32'(t2_rdy[c]));
            exp_rsp = (c >= 10) ? t2_rdy[c-10] : 4'h0;
            check_value("t2_rsp_valid", 32'(rsp_valid), 32'(exp_rsp != 4'h0));
            if (exp_rsp != 4'h0) begin
                exp_id = $clog2(exp_rsp);
                check_value("t2_rsp_id",     32'(rsp_id),     32'(exp_id));
                check_value("t2_rsp_sine",   32'(rsp_sine),   32'(to_q17($sin(angle_rad(t2_ang[exp_id])))));
                check_value("t2_rsp_cosine", 32'(rsp_cosine), 32'(to_q17($cos(angle_rad(t2_ang[exp_id])))));
            end
        end

        // T3: lone requester 2 against the MAX_OUT=2 cap
        do_reset();
        req_angle = 32'h0020_0000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = 4'b0100;
            #1;
            check_value("t3_ready", 32'(req_ready), ((c < 2) || (c == 11)) ? 32'h4 : 32'h0);
            check_value("t3_rsp_valid", 32'(rsp_valid), 32'((c == 10) || (c == 11)));
            if (rsp_valid) check_value("t3_rsp_id", 32'(rsp_id), 32'h2);
            if (c == 1) check_value("t3_cor_angle", 32'(cor_angle), 32'h20);
        end

        // T4: last grant 3, requesters 1 and 3 valid -> 1, 3, 1, then capped
        do_reset();
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        check_value("t4_ready_pre", 32'(req_ready), 32'h8);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req_valid = 4'b1010;
            #1;
            check_value("t4_ready", 32'(req_ready),
                        (c == 4) ? 32'h0 : (((c % 2) == 1) ? 32'h2 : 32'h8));
        end

        // T5: reset with three requests in flight
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 4'b0111;
            #1;
            check_value("t5_ready", 32'(req_ready), 32'(4'b0001 << c));
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        check_value("t5_busy_pre", 32'(busy), 32'h1);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'hF;
        #1;
        check_value("t5_rst_ready",     32'(req_ready), 32'h0);
        check_value("t5_rst_cor_angle", 32'(cor_angle), 32'h0);
        check_value("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_value("t5_rst_busy",      32'(busy),      32'h0);
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            rst       = 1'b1;
            req_valid = '0;
            #1;
            check_value("t5_quiet_rsp_valid", 32'(rsp_valid), 32'h0);
        end
        check_value("t5_quiet_rsp_sine", 32'(rsp_sine), 32'h0);
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        check_value("t5_first_grant", 32'(req_ready), 32'h1);

        // T6: requester 1 accepted in the cycle its earlier result returns
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            req_valid = ((c == 0) || ((c >= 10) && (c <= 12))) ? 4'b0010 : 4'b0000;
            #1;
            check_value("t6_rsp_valid", 32'(rsp_valid), 32'((c == 10) || (c == 20) || (c == 21)));
            if (rsp_valid) check_value("t6_rsp_id", 32'(rsp_id), 32'h1);
            if ((c == 0) || (c == 10) || (c == 11)) check_value("t6_ready", 32'(req_ready), 32'h2);
            if (c == 12) check_value("t6_ready_capped", 32'(req_ready), 32'h0);
            if ((c == 11) || (c == 21)) check_value("t6_busy", 32'(busy), 32'h1);
            if (c == 22) check_value("t6_busy_end", 32'(busy), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
